// File: rtl/multicycle_control_pkg.sv
// legv8_ctrl_pkg: shared types and encodings for the LEGv8 multicycle control unit.
//   - FSM state enum and instruction-class enum
//   - opcode match values/masks (Instruction[31:21])
//   - ALUCtrl, ALUSrcA, ALUSrcB and SignOp encodings
// Optional feature macro: MCTRL_ILLEGAL_TRAP_EN adds the HALT state.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
`ifdef MCTRL_ILLEGAL_TRAP_EN
    , ST_HALT
`endif
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LOAD,
    CLS_STORE,
    CLS_CBZ,
    CLS_B,
    CLS_MOVZ,
    CLS_ILLEGAL
  } iclass_t;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] SIGN_D    = 2'b00;
  localparam logic [1:0] SIGN_CB   = 2'b01;
  localparam logic [1:0] SIGN_B    = 2'b10;
  localparam logic [1:0] SIGN_MOVZ = 2'b11;

  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;
  localparam logic [10:0] MASK_MOVZ = 11'b11111111100;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_MOVZ = 11'b11010010100;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] val,
                                    input logic [10:0] mask);
    return (op & mask) == val;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// alu_op_decode: combinational opcode classifier.
// Ports:
//   opcode   in  OPW  Instruction[31:21]
//   iclass   out      instruction class (CLS_ILLEGAL when nothing matches)
//   alu_ctrl out 4    ALU operation the class uses in EXEC
module alu_op_decode
  import legv8_ctrl_pkg::*;
#(
  parameter int OPW = 11
) (
  input  logic [OPW-1:0] opcode,
  output iclass_t        iclass,
  output logic [3:0]     alu_ctrl
);

  always_comb begin
    iclass   = CLS_ILLEGAL;
    alu_ctrl = ALU_ADD;
    if (op_match(opcode, OP_ADD, MASK_FULL)) begin
      iclass   = CLS_R;
      alu_ctrl = ALU_ADD;
    end else if (op_match(opcode, OP_SUB, MASK_FULL)) begin
      iclass   = CLS_R;
      alu_ctrl = ALU_SUB;
    end else if (op_match(opcode, OP_AND, MASK_FULL)) begin
      iclass   = CLS_R;
      alu_ctrl = ALU_AND;
    end else if (op_match(opcode, OP_ORR, MASK_FULL)) begin
      iclass   = CLS_R;
      alu_ctrl = ALU_ORR;
    end else if (op_match(opcode, OP_LDUR, MASK_FULL)) begin
      iclass   = CLS_LOAD;
    end else if (op_match(opcode, OP_STUR, MASK_FULL)) begin
      iclass   = CLS_STORE;
    end else if (op_match(opcode, OP_CBZ, MASK_CBZ)) begin
      iclass   = CLS_CBZ;
      alu_ctrl = ALU_PASSB;
    end else if (op_match(opcode, OP_B, MASK_B)) begin
      iclass   = CLS_B;
    end else if (op_match(opcode, OP_MOVZ, MASK_MOVZ)) begin
      iclass   = CLS_MOVZ;
      alu_ctrl = ALU_PASSB;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: LEGv8 multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Ports:
//   CLK, Reset (sync, active-high), Opcode (Instruction[31:21]), Zero, MemReady
//   ALUCtrl, ALUSrcA, ALUSrcB, SignOp, Reg2Loc, IRWrite, PCWrite, PCSrc,
//   MemRead, MemWrite, MemtoReg, RegWrite, Illegal (trap build only)
// Macro MCTRL_ILLEGAL_TRAP_EN: illegal opcodes halt the FSM and raise Illegal;
// otherwise they retire as a NOP.
//
// state  | meaning
// FETCH  | read instruction, PC+4; leaves when MemReady
// DECODE | latch class/ALU op, compute branch target
// EXEC   | ALU op / address / branch resolve
// MEM    | data access, holds until MemReady
// WB     | register file write
// HALT   | illegal opcode trap, held until Reset (trap build only)
module multicycle_control
  import legv8_ctrl_pkg::*;
#(
  parameter int OPW = 11
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] Opcode,
  input  logic           Zero,
  input  logic           MemReady,
  output logic [3:0]     ALUCtrl,
  output logic [1:0]     ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     SignOp,
  output logic           Reg2Loc,
  output logic           IRWrite,
  output logic           PCWrite,
  output logic           PCSrc,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           MemtoReg,
  output logic           RegWrite
`ifdef MCTRL_ILLEGAL_TRAP_EN
  , output logic         Illegal
`endif
);

  state_t     state;
  iclass_t    cls;
  logic [3:0] alu_op;
  iclass_t    dec_cls;
  logic [3:0] dec_alu;

`ifdef MCTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
`endif

  alu_op_decode #(.OPW(OPW)) u_dec (
    .opcode   (Opcode),
    .iclass   (dec_cls),
    .alu_ctrl (dec_alu)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= ST_FETCH;
      cls    <= CLS_ILLEGAL;
      alu_op <= ALU_AND;
`ifdef MCTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FETCH: if (MemReady) state <= ST_DECODE;
        ST_DECODE: begin
          cls    <= dec_cls;
          alu_op <= dec_alu;
          if (dec_cls == CLS_ILLEGAL) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
            state     <= ST_HALT;
            illegal_q <= 1'b1;
`else
            state <= ST_FETCH;
`endif
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls)
            CLS_R, CLS_MOVZ:     state <= ST_WB;
            CLS_LOAD, CLS_STORE: state <= ST_MEM;
            default:             state <= ST_FETCH;
          endcase
        end
        ST_MEM: if (MemReady) state <= (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        ST_WB: state <= ST_FETCH;
`ifdef MCTRL_ILLEGAL_TRAP_EN
        ST_HALT: state <= ST_HALT;
`endif
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Outputs are decoded combinationally: IRWrite/PCWrite must follow MemReady
  // and Zero within the same cycle, and everything must read 0 while Reset=1.
  always_comb begin
    ALUCtrl  = ALU_AND;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_REGB;
    SignOp   = SIGN_D;
    Reg2Loc  = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    if (!Reset) begin
      case (state)
        ST_FETCH: begin
          MemRead = 1'b1;
          ALUSrcA = SRCA_PC;
          ALUSrcB = SRCB_FOUR;
          ALUCtrl = ALU_ADD;
          IRWrite = MemReady;
          PCWrite = MemReady;
        end
        ST_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM_SL2;
          ALUCtrl = ALU_ADD;
          Reg2Loc = (dec_cls == CLS_STORE) || (dec_cls == CLS_CBZ);
          // Target offset extension depends on the branch format.
          if (dec_cls == CLS_CBZ)    SignOp = SIGN_CB;
          else if (dec_cls == CLS_B) SignOp = SIGN_B;
        end
        ST_EXEC: begin
          case (cls)
            CLS_R: begin
              ALUSrcA = SRCA_REGA;
              ALUSrcB = SRCB_REGB;
              ALUCtrl = alu_op;
            end
            CLS_LOAD, CLS_STORE: begin
              ALUSrcA = SRCA_REGA;
              ALUSrcB = SRCB_IMM;
              ALUCtrl = ALU_ADD;
              SignOp  = SIGN_D;
            end
            CLS_CBZ: begin
              ALUSrcB = SRCB_REGB;
              ALUCtrl = ALU_PASSB;
              Reg2Loc = 1'b1;
              PCSrc   = 1'b1;
              PCWrite = Zero;
            end
            CLS_B: begin
              PCWrite = 1'b1;
              PCSrc   = 1'b1;
            end
            CLS_MOVZ: begin
              ALUSrcB = SRCB_IMM;
              SignOp  = SIGN_MOVZ;
              ALUCtrl = ALU_PASSB;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          // Keep the effective address stable across memory wait cycles.
          ALUSrcA  = SRCA_REGA;
          ALUSrcB  = SRCB_IMM;
          ALUCtrl  = ALU_ADD;
          MemRead  = (cls == CLS_LOAD);
          MemWrite = (cls == CLS_STORE);
        end
        ST_WB: begin
          RegWrite = 1'b1;
          MemtoReg = (cls == CLS_LOAD);
        end
        default: ;
      endcase
    end
  end

`ifdef MCTRL_ILLEGAL_TRAP_EN
  assign Illegal = illegal_q & ~Reset;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. A reference model turns each instruction into
// a per-cycle list of input drives and expected outputs; the runner replays it.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [10:0] Opcode = '0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic [3:0]  ALUCtrl;
  logic [1:0]  ALUSrcA, ALUSrcB, SignOp;
  logic        Reg2Loc, IRWrite, PCWrite, PCSrc, MemRead, MemWrite, MemtoReg, RegWrite;
`ifdef MCTRL_ILLEGAL_TRAP_EN
  logic        Illegal;
`endif

  multicycle_control #(.OPW(11)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .ALUCtrl(ALUCtrl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .SignOp(SignOp),
    .Reg2Loc(Reg2Loc), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite)
`ifdef MCTRL_ILLEGAL_TRAP_EN
    , .Illegal(Illegal)
`endif
  );

  always #5 CLK = ~CLK;

  localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_B = 4, K_MOVZ = 5, K_ILL = 6;

  // strobe vector order: IRWrite PCWrite MemRead MemWrite MemtoReg RegWrite
  localparam logic [5:0] S_IRW = 6'b100000, S_PCW = 6'b010000, S_MR = 6'b001000,
                         S_MW = 6'b000100, S_M2R = 6'b000010, S_RW = 6'b000001;

  typedef struct {
    logic        rst, mrdy, zero;
    logic [10:0] op;
    logic [5:0]  strb;
    logic        pcs, c_pcs, r2l, c_r2l;
    logic [3:0]  alu;
    logic        c_alu;
    logic [1:0]  sa, sb, sop;
    logic        c_sa, c_sb, c_sop;
    logic        ill;
  } ent_t;

  ent_t trace[$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int classify(input logic [10:0] op, output logic [3:0] alu);
    alu = 4'b0010;
    if (op == 11'b10001011000) return K_R;
    if (op == 11'b11001011000) begin alu = 4'b0110; return K_R; end
    if (op == 11'b10001010000) begin alu = 4'b0000; return K_R; end
    if (op == 11'b10101010000) begin alu = 4'b0001; return K_R; end
    if (op == 11'b11111000010) return K_LD;
    if (op == 11'b11111000000) return K_ST;
    if (op[10:3] == 8'b10110100) begin alu = 4'b0111; return K_CBZ; end
    if (op[10:5] == 6'b000101) return K_B;
    if (op[10:2] == 9'b110100101) begin alu = 4'b0111; return K_MOVZ; end
    return K_ILL;
  endfunction

  function automatic ent_t blank();
    ent_t e;
    e.rst = 1'b0; e.mrdy = 1'($urandom_range(0, 1)); e.zero = 1'($urandom_range(0, 1));
    e.op = 11'($urandom);
    e.strb = '0; e.pcs = 0; e.c_pcs = 0; e.r2l = 0; e.c_r2l = 0;
    e.alu = '0; e.c_alu = 0; e.sa = '0; e.sb = '0; e.sop = '0;
    e.c_sa = 0; e.c_sb = 0; e.c_sop = 0; e.ill = 0;
    return e;
  endfunction

  task automatic push_reset(input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e = blank();
      e.rst = 1'b1; e.mrdy = 1'b1;
      e.c_pcs = 1; e.c_r2l = 1; e.c_alu = 1; e.c_sa = 1; e.c_sb = 1; e.c_sop = 1;
      trace.push_back(e);
    end
  endtask

  task automatic push_fetch(input int waits);
    ent_t e;
    for (int i = 0; i <= waits; i++) begin
      e = blank();
      e.mrdy = (i == waits);
      e.strb = (i == waits) ? (S_MR | S_IRW | S_PCW) : S_MR;
      e.sa = 2'b00; e.c_sa = 1; e.sb = 2'b01; e.c_sb = 1; e.alu = 4'b0010; e.c_alu = 1;
      e.pcs = 1'b0; e.c_pcs = (i == waits);
      trace.push_back(e);
    end
  endtask

  task automatic push_instr(input logic [10:0] op, input int fw, input int mw,
                            input logic z, input bit rst_in_mem);
    ent_t e;
    logic [3:0] alu;
    int k;
    k = classify(op, alu);
    push_fetch(fw);
    // DECODE
    e = blank();
    e.op = op;
    e.sa = 2'b01; e.sb = 2'b11; e.alu = 4'b0010; e.c_sa = 1; e.c_sb = 1; e.c_alu = 1;
    e.r2l = (k == K_ST) || (k == K_CBZ); e.c_r2l = 1;
    trace.push_back(e);
    if (k == K_ILL) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) begin
        e = blank();
        e.ill = 1'b1;
        trace.push_back(e);
      end
      push_reset(2);
`endif
      return;
    end
    // EXEC
    e = blank();
    case (k)
      K_R: begin
        e.sa = 2'b10; e.sb = 2'b00; e.alu = alu; e.c_sa = 1; e.c_sb = 1; e.c_alu = 1;
      end
      K_LD, K_ST: begin
        e.sa = 2'b10; e.sb = 2'b10; e.alu = 4'b0010; e.sop = 2'b00;
        e.c_sa = 1; e.c_sb = 1; e.c_alu = 1; e.c_sop = 1;
      end
      K_CBZ: begin
        e.zero = z;
        e.sb = 2'b00; e.alu = 4'b0111; e.r2l = 1; e.c_sb = 1; e.c_alu = 1; e.c_r2l = 1;
        if (z) begin e.strb = S_PCW; e.pcs = 1; e.c_pcs = 1; end
      end
      K_B: begin
        e.strb = S_PCW; e.pcs = 1; e.c_pcs = 1;
      end
      default: begin
        e.sb = 2'b10; e.sop = 2'b11; e.alu = 4'b0111; e.c_sb = 1; e.c_sop = 1; e.c_alu = 1;
      end
    endcase
    trace.push_back(e);
    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i <= mw; i++) begin
        e = blank();
        e.mrdy = (i == mw);
        e.strb = (k == K_LD) ? S_MR : S_MW;
        if (rst_in_mem) begin
          e.mrdy = 1'b0;
          trace.push_back(e);
          push_reset(3);
          return;
        end
        trace.push_back(e);
      end
      if (k == K_ST) return;
    end
    if (k == K_R || k == K_MOVZ || k == K_LD) begin
      e = blank();
      e.strb = S_RW | ((k == K_LD) ? S_M2R : 6'b0);
      trace.push_back(e);
    end
  endtask

  function automatic logic [10:0] rand_op();
    logic [10:0] rops [4];
    logic [10:0] op;
    logic [3:0]  a;
    rops[0] = 11'b10001011000; rops[1] = 11'b11001011000;
    rops[2] = 11'b10001010000; rops[3] = 11'b10101010000;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: op = rops[$urandom_range(0, 3)];
      4: op = 11'b11111000010;
      5: op = 11'b11111000000;
      6: op = {8'b10110100, 3'($urandom)};
      7: op = {6'b000101, 5'($urandom)};
      8: op = {9'b110100101, 2'($urandom)};
      default: begin
        op = 11'($urandom);
        while (classify(op, a) != K_ILL) op = 11'($urandom);
      end
    endcase
    return op;
  endfunction

  initial begin
    ent_t e;
    push_reset(3);
    push_instr(11'b10001011000, 0, 0, 1'b0, 0);   // ADD
    push_instr(11'b11111000010, 0, 2, 1'b0, 0);   // LDUR, 2 MEM waits
    push_instr(11'b10110100101, 0, 0, 1'b1, 0);   // CBZ taken
    push_instr(11'b10110100010, 0, 0, 1'b0, 0);   // CBZ not taken
    push_instr(11'b11010010100, 0, 0, 1'b0, 0);   // MOVZ
    push_instr(11'b00010111111, 2, 0, 1'b0, 0);   // B with fetch waits
    push_instr(11'b11111000000, 1, 2, 1'b0, 0);   // STUR
    push_instr(11'b11111000010, 0, 1, 1'b0, 1);   // LDUR reset in MEM
    push_instr(11'b11001011000, 0, 0, 1'b0, 0);   // SUB
    push_instr(11'b00000000000, 0, 0, 1'b0, 0);   // illegal
    push_instr(11'b10101010000, 0, 0, 1'b0, 0);   // ORR
    for (int n = 0; n < 60; n++)
      push_instr(rand_op(), $urandom_range(0, 2), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), 0);

    foreach (trace[i]) begin
      e = trace[i];
      @(posedge CLK);
      #1;
      Reset = e.rst; MemReady = e.mrdy; Zero = e.zero; Opcode = e.op;
      @(negedge CLK);
      check_val($sformatf("strobes@%0d", i),
                {26'b0, IRWrite, PCWrite, MemRead, MemWrite, MemtoReg, RegWrite}, {26'b0, e.strb});
      if (e.c_alu) check_val($sformatf("alu@%0d", i), {28'b0, ALUCtrl}, {28'b0, e.alu});
      if (e.c_sa)  check_val($sformatf("srca@%0d", i), {30'b0, ALUSrcA}, {30'b0, e.sa});
      if (e.c_sb)  check_val($sformatf("srcb@%0d", i), {30'b0, ALUSrcB}, {30'b0, e.sb});
      if (e.c_sop) check_val($sformatf("signop@%0d", i), {30'b0, SignOp}, {30'b0, e.sop});
      if (e.c_pcs) check_val($sformatf("pcsrc@%0d", i), {31'b0, PCSrc}, {31'b0, e.pcs});
      if (e.c_r2l) check_val($sformatf("reg2loc@%0d", i), {31'b0, Reg2Loc}, {31'b0, e.r2l});
`ifdef MCTRL_ILLEGAL_TRAP_EN
      check_val($sformatf("illegal@%0d", i), {31'b0, Illegal}, {31'b0, e.ill});
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
